// File: rtl/fetch_stage_pkg.sv
// Shared pipeline constants for the instruction-fetch stage: memory base,
// NOP encoding, fault code and the fetch-address fault rule.
package fetch_stage_pkg;

  localparam logic [31:0] IM_BASE_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP             = 32'h0000_0000;
  localparam logic [4:0]  EXC_ADEL        = 5'd4;

  typedef enum logic {
    PASS = 1'b0,
    HOLD = 1'b1
  } hold_state_t;

  // The limit is one bit wider so a window ending at 2^32 still compares correctly.
  function automatic logic fetch_fault(input logic [31:0] pc,
                                       input logic [31:0] base,
                                       input logic [32:0] limit);
    return (pc[1:0] != 2'b00) || (pc < base) || ({1'b0, pc} >= limit);
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Captures the in-flight memory word when decode stalls and selects what
// decode sees: memory data, the held word, or a NOP for bubbles/faults.
module fetch_hold_buf
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        squash,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr
);

  hold_state_t state;
  hold_state_t state_next;
  logic        load_hold;
  logic [31:0] hold_instr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= PASS;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_hold  = 1'b0;
    if (flush) begin
      state_next = PASS;
    end else if (stall) begin
      state_next = HOLD;
      load_hold  = (state == PASS);
    end else begin
      state_next = PASS;
    end
  end

  // Only the first stalled edge samples memory; later edges see re-read garbage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_instr <= NOP;
    end else if (load_hold) begin
      hold_instr <= imem_rdata;
    end
  end

  assign instr = squash ? NOP : ((state == HOLD) ? hold_instr : imem_rdata);

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID register: drives the synchronous
// instruction memory and presents instruction, PC, link address and fault.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] IM_BASE  = IM_BASE_DEFAULT,
  parameter int          IM_WORDS = 4096,
  parameter int          AW       = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   pc_i,
  input  logic          stall,
  input  logic          flush,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   instr_d,
  output logic [31:0]   pc_d,
  output logic [31:0]   pc8_d,
  output logic          valid_d,
  output logic          adel_d,
  output logic [31:0]   fetch_cnt
);

  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) * 33'd4);

  logic [31:0] pc_q;
  logic        valid_q;
  logic        adel_q;
  logic        fault;

  // Out-of-range addresses still index memory; the fault flag squashes the data.
  assign imem_addr = AW'((pc_i - IM_BASE) >> 2);
  assign fault     = fetch_fault(pc_i, IM_BASE, IM_LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= 32'h0;
      valid_q   <= 1'b0;
      adel_q    <= 1'b0;
      fetch_cnt <= 32'h0;
    end else if (flush) begin
      pc_q    <= 32'h0;
      valid_q <= 1'b0;
      adel_q  <= 1'b0;
    end else if (!stall) begin
      if (valid_q) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      pc_q    <= pc_i;
      valid_q <= 1'b1;
      adel_q  <= fault;
    end
  end

  fetch_hold_buf u_hold_buf (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .flush      (flush),
    .squash     (!valid_q || adel_q),
    .imem_rdata (imem_rdata),
    .instr      (instr_d)
  );

  assign pc_d    = pc_q;
  assign pc8_d   = pc_q + 32'd8;
  assign valid_d = valid_q;
  assign adel_d  = adel_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a behavioural IF/ID model checked every
// negedge, plus hand-computed literal checks at key points.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_i = 32'h3000;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr_d, pc_d, pc8_d, fetch_cnt;
  logic        valid_d, adel_d;
  logic        garbage = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Model state: what decode should see, kept as plain values.
  logic [31:0] m_pc = 32'h0;
  logic        m_valid = 1'b0;
  logic        m_adel = 1'b0;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_cnt = 32'h0;
  logic [31:0] cnt_ofs = 32'h0;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .pc_i       (pc_i),
    .stall      (stall),
    .flush      (flush),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .pc8_d      (pc8_d),
    .valid_d    (valid_d),
    .adel_d     (adel_d),
    .fetch_cnt  (fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] byte_addr);
    return {16'hC0DE, byte_addr[15:0]};
  endfunction

  // Synchronous-read memory; garbage mode models re-reads of other addresses.
  always @(posedge clk) begin
    if (garbage) imem_rdata <= $urandom;
    else         imem_rdata <= word_at(32'h3000 + 32'({imem_addr, 2'b00}));
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc = 0; m_valid = 0; m_adel = 0; m_instr = 0; m_cnt = 0;
    end else if (flush) begin
      m_pc = 0; m_valid = 0; m_adel = 0;
    end else if (!stall) begin
      if (m_valid) m_cnt = m_cnt + 1;
      m_pc    = pc_i;
      m_valid = 1;
      m_adel  = (pc_i % 4 != 0) || (pc_i < 32'h3000) || (pc_i >= 32'h7000);
      m_instr = word_at(pc_i);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("instr_d", instr_d, (m_valid && !m_adel) ? m_instr : 32'h0);
    checkOutput("pc_d", pc_d, m_pc);
    checkOutput("pc8_d", pc8_d, m_pc + 32'd8);
    checkOutput("valid_d", {31'h0, valid_d}, {31'h0, m_valid});
    checkOutput("adel_d", {31'h0, adel_d}, {31'h0, m_adel});
    checkOutput("fetch_cnt", fetch_cnt, m_cnt + cnt_ofs);
  end

  task automatic applyStimulus(input logic [31:0] pc, input logic st,
                               input logic fl, input logic gb);
    pc_i = pc; stall = st; flush = fl; garbage = gb;
    @(posedge clk);
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " instr_d"}, instr_d, 32'h0);
    checkOutput({tag, " pc_d"}, pc_d, 32'h0);
    checkOutput({tag, " pc8_d"}, pc8_d, 32'h8);
    checkOutput({tag, " valid_d"}, {31'h0, valid_d}, 32'h0);
    checkOutput({tag, " fetch_cnt"}, fetch_cnt, 32'h0);
  endtask

  initial begin
    #3;
    checkReset("reset");
    @(negedge clk);
    #1 reset = 1'b1;

    applyStimulus(32'h3000, 0, 0, 0);
    checkOutput("lit pc_d A", pc_d, 32'h3000);
    checkOutput("lit instr A", instr_d, 32'hC0DE3000);
    checkOutput("lit pc8 A", pc8_d, 32'h3008);
    checkOutput("lit valid A", {31'h0, valid_d}, 32'h1);
    applyStimulus(32'h3004, 0, 0, 0);
    checkOutput("lit instr B", instr_d, 32'hC0DE3004);
    checkOutput("lit pc8 B", pc8_d, 32'h300C);
    checkOutput("lit cnt B", fetch_cnt, 32'd1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(32'h3008, 1, 0, 1);
      checkOutput("lit stall instr", instr_d, 32'hC0DE3004);
      checkOutput("lit stall pc", pc_d, 32'h3004);
      checkOutput("lit stall cnt", fetch_cnt, 32'd1);
    end
    applyStimulus(32'h3008, 0, 0, 0);
    checkOutput("lit instr C", instr_d, 32'hC0DE3008);
    checkOutput("lit pc8 C", pc8_d, 32'h3010);
    checkOutput("lit cnt C", fetch_cnt, 32'd2);

    applyStimulus(32'h300C, 1, 1, 0);
    checkOutput("lit flush valid", {31'h0, valid_d}, 32'h0);
    checkOutput("lit flush instr", instr_d, 32'h0);
    checkOutput("lit flush pc", pc_d, 32'h0);
    applyStimulus(32'h300C, 0, 0, 0);
    checkOutput("lit post-flush pc", pc_d, 32'h300C);
    checkOutput("lit post-flush instr", instr_d, 32'hC0DE300C);

    applyStimulus(32'h3002, 0, 0, 0);
    checkOutput("lit adel misalign", {30'h0, valid_d, adel_d}, 32'h3);
    checkOutput("lit adel instr", instr_d, 32'h0);
    checkOutput("lit cnt end", fetch_cnt, 32'd3);
    applyStimulus(32'h2FFC, 0, 0, 0);
    checkOutput("lit adel low", {30'h0, valid_d, adel_d}, 32'h3);
    applyStimulus(32'h7000, 0, 0, 0);
    checkOutput("lit adel high", {30'h0, valid_d, adel_d}, 32'h3);
    checkOutput("lit adel high instr", instr_d, 32'h0);
    applyStimulus(32'h6FFC, 0, 0, 0);
    checkOutput("lit last word", instr_d, 32'hC0DE6FFC);
    checkOutput("lit last adel", {31'h0, adel_d}, 32'h0);

    applyStimulus(32'h3010, 0, 0, 0);
    applyStimulus(32'h3014, 1, 0, 1);
    #2 reset = 1'b0;
    #1 checkReset("async reset");
    @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    applyStimulus(32'h3000, 0, 0, 0);
    checkOutput("lit restart pc", pc_d, 32'h3000);
    checkOutput("lit restart instr", instr_d, 32'hC0DE3000);

    applyStimulus(32'h3004, 0, 0, 0);
    force dut.fetch_cnt = 32'hFFFF_FFFF;
    cnt_ofs = 32'hFFFF_FFFF - m_cnt;
    #2 release dut.fetch_cnt;
    applyStimulus(32'h3008, 0, 0, 0);
    checkOutput("lit cnt wrap", fetch_cnt, 32'h0);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
